// File: rtl/gstdmasnd.sv
// gstdmasnd: FIFO-buffered 8-bit stereo/mono audio sender with a divided, rate-selectable sample tick.
// Optional feature: define GSTDMASND_UNDERRUN_EN to add the sticky underrun output.
module gstdmasnd #(
  parameter int unsigned FIFO_ADDR_BITS = 3,
  parameter int unsigned BASE_DIV       = 640
) (
  input  logic                    clk32,
  input  logic                    resb,
  input  logic                    mode_we,
  input  logic [2:0]              mode_in,
  input  logic                    SLOAD_N,
  input  logic [15:0]             MDIN,
  input  logic                    flush,
  output logic                    SREQ,
  output logic [7:0]              audio_left,
  output logic [7:0]              audio_right,
  output logic                    sample_tick,
  output logic [FIFO_ADDR_BITS:0] level
`ifdef GSTDMASND_UNDERRUN_EN
  ,
  output logic                    underrun
`endif
);

  localparam int unsigned Depth = 1 << FIFO_ADDR_BITS;
  localparam int unsigned DivW  = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam logic [DivW-1:0]           DivMax   = DivW'(BASE_DIV - 1);
  localparam logic [FIFO_ADDR_BITS:0]   DepthCnt = {1'b1, {FIFO_ADDR_BITS{1'b0}}};
  localparam logic [FIFO_ADDR_BITS:0]   CntOne   = (FIFO_ADDR_BITS + 1)'(1);
  localparam logic [FIFO_ADDR_BITS-1:0] PtrOne   = FIFO_ADDR_BITS'(1);

  // Timebase
  logic [DivW-1:0] div_q, div_d;
  logic [2:0]      rate_cnt_q, rate_cnt_d;
  logic            tick_q, tick_d;
  logic            base_tick, rate_hit;

  // Control
  logic [2:0] mode_q, mode_d;
  logic       sload_q, sload_d;
  logic       bytesel_q, bytesel_d;
  logic       mono;

  // FIFO
  logic [15:0]               mem_q [Depth];
  logic [FIFO_ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_ADDR_BITS:0]   cnt_q, cnt_d;
  logic [15:0]               rd_data;
  logic                      have_data, push, push_ok, pop, wr_en;

  // Outputs
  logic [7:0] audio_l_q, audio_l_d;
  logic [7:0] audio_r_q, audio_r_d;
  logic [7:0] mono_byte;
`ifdef GSTDMASND_UNDERRUN_EN
  logic       underrun_q, underrun_d;
`endif

  assign mono    = mode_q[2];
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    base_tick  = (div_q == '0);
    div_d      = (div_q == DivMax) ? '0 : div_q + DivW'(1);
    rate_cnt_d = base_tick ? rate_cnt_q + 3'd1 : rate_cnt_q;
    case (mode_q[1:0])
      2'b11:   rate_hit = 1'b1;
      2'b10:   rate_hit = ~rate_cnt_q[0];
      2'b01:   rate_hit = (rate_cnt_q[1:0] == 2'b00);
      default: rate_hit = (rate_cnt_q == 3'd0);
    endcase
    tick_d = base_tick & rate_hit;
  end

  always_comb begin
    sload_d   = SLOAD_N;
    mode_d    = mode_we ? mode_in : mode_q;
    have_data = (cnt_q != '0);
    push      = sload_q & ~SLOAD_N;
    // In mono a word is consumed only after its low byte has been played.
    pop       = tick_q & have_data & (~mono | bytesel_q);
    // A full FIFO still takes a word when the same cycle frees a slot.
    push_ok   = push & ((cnt_q != DepthCnt) | pop);
    wr_en     = push_ok & ~flush;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop)     rd_ptr_d = rd_ptr_q + PtrOne;
      case ({push_ok, pop})
        2'b10:   cnt_d = cnt_q + CntOne;
        2'b01:   cnt_d = cnt_q - CntOne;
        default: cnt_d = cnt_q;
      endcase
    end

    bytesel_d = bytesel_q;
    if (flush || mode_we) begin
      bytesel_d = 1'b0;
    end else if (tick_q && have_data && mono) begin
      bytesel_d = ~bytesel_q;
    end
  end

  always_comb begin
    mono_byte = bytesel_q ? rd_data[7:0] : rd_data[15:8];
    audio_l_d = audio_l_q;
    audio_r_d = audio_r_q;
    if (!flush && tick_q) begin
      if (have_data) begin
        if (mono) begin
          audio_l_d = mono_byte ^ 8'h80;
          audio_r_d = mono_byte ^ 8'h80;
        end else begin
          audio_l_d = rd_data[15:8] ^ 8'h80;
          audio_r_d = rd_data[7:0] ^ 8'h80;
        end
      end
`ifdef GSTDMASND_UNDERRUN_EN
      else begin
        audio_l_d = 8'h80;
        audio_r_d = 8'h80;
      end
`endif
    end
  end

`ifdef GSTDMASND_UNDERRUN_EN
  always_comb begin
    underrun_d = underrun_q;
    if (flush) begin
      underrun_d = 1'b0;
    end else if (tick_q && !have_data) begin
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= underrun_d;
    end
  end

  assign underrun = underrun_q;
`endif

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      div_q      <= '0;
      rate_cnt_q <= '0;
      tick_q     <= 1'b0;
      mode_q     <= '0;
      sload_q    <= 1'b1;
      bytesel_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      audio_l_q  <= 8'h80;
      audio_r_q  <= 8'h80;
    end else begin
      div_q      <= div_d;
      rate_cnt_q <= rate_cnt_d;
      tick_q     <= tick_d;
      mode_q     <= mode_d;
      sload_q    <= sload_d;
      bytesel_q  <= bytesel_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      audio_l_q  <= audio_l_d;
      audio_r_q  <= audio_r_d;
    end
  end

  // Sample storage carries no reset; validity is tracked by the count.
  always_ff @(posedge clk32) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= MDIN;
    end
  end

  assign SREQ        = (cnt_q != DepthCnt);
  assign level       = cnt_q;
  assign sample_tick = tick_q;
  assign audio_left  = audio_l_q;
  assign audio_right = audio_r_q;

endmodule
